muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstN  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port reqValid  in  1  request present.
REQ-006 SHALL have port reqReady  out  1  unit can accept a request.
REQ-007 SHALL have port reqOp  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports reqOp1, reqOp2  in  XLEN  rs1, rs2 operands.
REQ-009 SHALL have port reqTag  in  TAG_W  tag carried unmodified to the response.
REQ-010 SHALL have port flush  in  1  abort any operation in flight.
REQ-011 SHALL have port respValid  out  1  result present.
REQ-012 SHALL have port respReady  in  1  consumer takes the result.
REQ-013 SHALL have ports respResult (out, XLEN) and respTag (out, TAG_W).
REQ-014 SHALL have port busy  out  1  high when state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE, CALC, DONE; reqReady = (state==IDLE), combinational from state only.
REQ-016 Accept SHALL occur on an edge where reqValid and reqReady are high: latch op, operands and tag; go to CALC, or to DONE for early-out cases.
REQ-017 Division SHALL be restoring, 1 quotient bit per cycle on operand magnitudes; CALC lasts XLEN cycles, then DONE.
REQ-018 Multiply (iterative build) SHALL be shift-add over a 2*XLEN product, 1 bit per cycle; CALC lasts XLEN cycles.
REQ-019 respValid SHALL be high exactly while in DONE; iterative latency = XLEN+1 edges from accept to first respValid cycle.
REQ-020 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN] with signed x signed, signed x unsigned, and unsigned x unsigned operands respectively.
REQ-021 Signed ops SHALL work on magnitudes and negate the result at the end: quotient sign = op1 sign XOR op2 sign; remainder sign = op1 sign.
REQ-022 Divide by zero SHALL early-out to DONE on the next edge: DIV/DIVU result all-ones; REM/REMU result op1.
REQ-023 Signed overflow (op1 = most-negative, op2 = -1) SHALL early-out: DIV result op1; REM result 0.
REQ-024 In DONE, respResult/respTag SHALL stay stable until the edge with respReady high; that edge SHALL go to IDLE; no new accept on the same edge.
REQ-025 flush SHALL force IDLE on the next edge from any state, drop any pending result, and take priority over accept and the response handshake.
REQ-026 Inputs reqOp1/reqOp2/reqOp SHALL be ignored outside the accept edge.

Reset
REQ-027 Asserting rstN low SHALL immediately force IDLE, respValid=0, respResult=0, respTag=0, busy=0 and clear the counter/accumulators; reqReady=1.
REQ-028 Reset during CALC or DONE SHALL discard the operation; no response is produced after reset release.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN, when defined, SHALL compile in a single-cycle XLEN x XLEN multiplier: multiply ops go directly to DONE, latency 1 edge; division remains iterative.
REQ-030 Without MULDIV_FAST_MUL_EN, multiply SHALL use the iterative datapath of REQ-018 with no multiplier array.

Verification
REQ-031 DIV with op1=-7 (0xFFFFFFF9), op2=2, tag 3 -> respResult 0xFFFFFFFD, respTag 3, respValid 33 edges after accept; REM of the same operands -> 0xFFFFFFFF.
REQ-032 DIVU with op1=5, op2=0 -> 0xFFFFFFFF after 1 edge; REMU with the same operands -> 5.
REQ-033 DIV with op1=0x80000000, op2=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-034 MULH with op1=0x80000000, op2=0x80000000 -> 0x40000000; MULHU with op1=0xFFFFFFFF, op2=0xFFFFFFFF -> 0xFFFFFFFE; latency 33 edges, or 1 edge with MULDIV_FAST_MUL_EN.
REQ-035 Hold respReady low for 5 cycles in DONE -> respValid/respResult stable; reqReady=0 throughout; flush asserted mid-CALC -> IDLE next edge, no response.
REQ-036 rstN low for 1 cycle mid-CALC -> all outputs at reset values immediately; next request completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit.
// Division is restoring and produces 1 quotient bit per cycle.
// By default multiply is shift-add and produces 1 bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier array for multiply ops.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [2:0]       reqOp,
  input  logic [XLEN-1:0]  reqOp1,
  input  logic [XLEN-1:0]  reqOp2,
  input  logic [TAG_W-1:0] reqTag,
  input  logic             flush,
  output logic             respValid,
  input  logic             respReady,
  output logic [XLEN-1:0]  respResult,
  output logic [TAG_W-1:0] respTag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic             op1_signed, op2_signed, op1_neg, op2_neg, neg_sel;
  logic [XLEN-1:0]  mag1, mag2;
  logic [XLEN:0]    shifted, diff, sum;
  logic [XLEN-1:0]  step_acc, step_quo;

  // Sign-correct the full product, then pick the low or high half.
  function automatic logic [XLEN-1:0] mul_select(input logic [2*XLEN-1:0] prod,
                                                 input logic neg, input logic [2:0] op);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Sign-correct the quotient or remainder magnitude, depending on which one the op returns.
  function automatic logic [XLEN-1:0] div_select(input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] rem,
                                                 input logic neg, input logic [2:0] op);
    logic [XLEN-1:0] q, r;
    q = neg ? -quo : quo;
    r = neg ? -rem : rem;
    return op[1] ? r : q;
  endfunction

  // Reduce the incoming operands to magnitudes and record whether the result must be negated.
  always_comb begin
    op1_signed = (reqOp == OP_MULH) || (reqOp == OP_MULHSU) || (reqOp == OP_DIV) || (reqOp == OP_REM);
    op2_signed = (reqOp == OP_MULH) || (reqOp == OP_DIV) || (reqOp == OP_REM);
    op1_neg    = op1_signed & reqOp1[XLEN-1];
    op2_neg    = op2_signed & reqOp2[XLEN-1];
    mag1       = op1_neg ? -reqOp1 : reqOp1;
    mag2       = op2_neg ? -reqOp2 : reqOp2;
    neg_sel    = (reqOp == OP_REM) ? op1_neg : (op1_neg ^ op2_neg);
  end

  // Perform one iteration of either the restoring divide or the shift-add multiply.
  always_comb begin
    shifted  = {acc_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    sum      = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    step_acc = acc_q;
    step_quo = quo_q;
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        step_acc = diff[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        step_acc = shifted[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {step_acc, step_quo} = {sum, quo_q[XLEN-1:1]};
    end
  end

  // Compute the next state. Early-out cases are handled here, and flush overrides everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          op_d  = reqOp;
          tag_d = reqTag;
          cnt_d = '0;
          neg_d = neg_sel;
          acc_d = '0;
          if (reqOp[2]) begin
            if (reqOp2 == '0) begin
              res_d   = reqOp[1] ? reqOp1 : '1;
              state_d = DONE;
            end else if (!reqOp[0] && (reqOp1 == MOST_NEG) && (reqOp2 == '1)) begin
              res_d   = reqOp[1] ? '0 : reqOp1;
              state_d = DONE;
            end else begin
              quo_d   = mag1;
              dvs_d   = mag2;
              state_d = CALC;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            res_d   = mul_select((2*XLEN)'(mag1) * (2*XLEN)'(mag2), neg_sel, reqOp);
            state_d = DONE;
`else
            quo_d   = mag2;
            dvs_d   = mag1;
            state_d = CALC;
`endif
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = step_acc;
        quo_d = step_quo;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          res_d   = op_q[2] ? div_select(step_quo, step_acc, neg_q, op_q)
                            : mul_select({step_acc, step_quo}, neg_q, op_q);
        end
      end
      DONE: begin
        if (respReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Register all state. An asynchronous reset clears the FSM, counter, accumulators and outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign reqReady   = (state_q == IDLE);
  assign respValid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign respResult = res_q;
  assign respTag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit at XLEN=32.
// Expected values come from plain 64-bit arithmetic, using the RV32M rules for divide by zero and overflow.
module tb_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic             clk;
  logic             rstN;
  logic             reqValid;
  logic             reqReady;
  logic [2:0]       reqOp;
  logic [XLEN-1:0]  reqOp1;
  logic [XLEN-1:0]  reqOp2;
  logic [TAG_W-1:0] reqTag;
  logic             flush;
  logic             respValid;
  logic             respReady;
  logic [XLEN-1:0]  respResult;
  logic [TAG_W-1:0] respTag;
  logic             busy;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqOp      (reqOp),
    .reqOp1     (reqOp1),
    .reqOp2     (reqOp2),
    .reqTag     (reqTag),
    .flush      (flush),
    .respValid  (respValid),
    .respReady  (respReady),
    .respResult (respResult),
    .respTag    (respTag),
    .busy       (busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // A single comparison: count it, and report it if it fails.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result, taken from the RV32M definitions.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Number of edges from the accept edge up to the first respValid cycle.
  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == MOST_NEG && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return MUL_LAT;
  endfunction

  // Issue one request and check the response. The result is held for holdCycles before it is taken.
  task automatic applyStimulus(input string label, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag, input int holdCycles);
    logic [31:0] expRes;
    int          expLat;
    int          edges;
    expRes = refResult(op, a, b);
    expLat = refLatency(op, a, b);
    @(negedge clk);
    checkOutput({label, "/ready_idle"}, 64'(reqReady), 64'd1);
    reqValid = 1'b1;
    reqOp    = op;
    reqOp1   = a;
    reqOp2   = b;
    reqTag   = tag;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqOp    = 3'($urandom);
    reqOp1   = $urandom;
    reqOp2   = $urandom;
    reqTag   = 5'($urandom);
    edges = 1;
    while (!respValid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({label, "/latency"}, 64'(edges), 64'(expLat));
    checkOutput({label, "/result"}, 64'(respResult), 64'(expRes));
    checkOutput({label, "/tag"}, 64'(respTag), 64'(tag));
    checkOutput({label, "/busy"}, 64'(busy), 64'd1);
    checkOutput({label, "/ready_done"}, 64'(reqReady), 64'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({label, "/hold_valid"}, 64'(respValid), 64'd1);
      checkOutput({label, "/hold_result"}, 64'(respResult), 64'(expRes));
      checkOutput({label, "/hold_ready"}, 64'(reqReady), 64'd0);
    end
    @(negedge clk);
    respReady = 1'b1;
    reqValid  = 1'b1;
    @(posedge clk);
    #1;
    respReady = 1'b0;
    reqValid  = 1'b0;
    checkOutput({label, "/release_valid"}, 64'(respValid), 64'd0);
    checkOutput({label, "/release_no_accept"}, 64'(reqReady), 64'd1);
  endtask

  // Main sequence of directed steps followed by randomized operations.
  initial begin
    logic [2:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    logic        sawValid;

    rstN      = 1'b0;
    reqValid  = 1'b0;
    reqOp     = '0;
    reqOp1    = '0;
    reqOp2    = '0;
    reqTag    = '0;
    flush     = 1'b0;
    respReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/ready", 64'(reqReady), 64'd1);
    checkOutput("reset/valid", 64'(respValid), 64'd0);
    checkOutput("reset/busy", 64'(busy), 64'd0);
    checkOutput("reset/result", 64'(respResult), 64'd0);
    checkOutput("reset/tag", 64'(respTag), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    $display("[TB] reset released");

    applyStimulus("div_neg7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    applyStimulus("rem_neg7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    applyStimulus("divu_by0", 3'd5, 32'd5, 32'd0, 5'd7, 0);
    applyStimulus("remu_by0", 3'd7, 32'd5, 32'd0, 5'd8, 0);
    applyStimulus("div_ovf", 3'd4, MOST_NEG, 32'hFFFF_FFFF, 5'd9, 0);
    applyStimulus("rem_ovf", 3'd6, MOST_NEG, 32'hFFFF_FFFF, 5'd10, 0);
    applyStimulus("mulh_min", 3'd1, MOST_NEG, MOST_NEG, 5'd11, 0);
    applyStimulus("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 0);
    applyStimulus("mulhsu_mix", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd13, 0);
    applyStimulus("mul_hold", 3'd0, 32'd12345, 32'hFFFF_FFFD, 5'd14, 5);

    $display("[TB] flush mid-calc");
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = 3'd5;
    reqOp1   = 32'd1000;
    reqOp2   = 32'd7;
    reqTag   = 5'd20;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_calc/ready", 64'(reqReady), 64'd1);
    checkOutput("flush_calc/busy", 64'(busy), 64'd0);
    checkOutput("flush_calc/valid", 64'(respValid), 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (respValid) sawValid = 1'b1;
    end
    checkOutput("flush_calc/no_resp", 64'(sawValid), 64'd0);

    $display("[TB] flush in done and flush against accept");
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = 3'd4;
    reqOp1   = 32'd9;
    reqOp2   = 32'd0;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    checkOutput("flush_done/valid_before", 64'(respValid), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_done/valid_after", 64'(respValid), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    reqValid = 1'b0;
    checkOutput("flush_accept/ready", 64'(reqReady), 64'd1);

    $display("[TB] reset mid-calc");
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = 3'd6;
    reqOp1   = 32'd77;
    reqOp2   = 32'd5;
    reqTag   = 5'd31;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rst_calc/ready", 64'(reqReady), 64'd1);
    checkOutput("rst_calc/valid", 64'(respValid), 64'd0);
    checkOutput("rst_calc/busy", 64'(busy), 64'd0);
    checkOutput("rst_calc/result", 64'(respResult), 64'd0);
    checkOutput("rst_calc/tag", 64'(respTag), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (respValid) sawValid = 1'b1;
    end
    checkOutput("rst_calc/no_resp", 64'(sawValid), 64'd0);
    applyStimulus("after_reset", 3'd4, 32'd100, 32'hFFFF_FFFD, 5'd17, 1);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      rOp = 3'($urandom);
      rA  = $urandom;
      rB  = $urandom;
      case ($urandom_range(0, 5))
        0: rB = 32'd0;
        1: begin rA = MOST_NEG; rB = 32'hFFFF_FFFF; end
        2: rB = 32'($urandom_range(1, 15));
        3: rB = -32'($urandom_range(1, 15));
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d_op%0d", i, rOp), rOp, rA, rB, 5'($urandom), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
